// File: rtl/usb_rx_phy_decoder.sv
// usb_rx_phy_decoder: USB receive bit-level stage.
// NRZI decode, SYNC detect, unstuffing, byte assembly, EOP and line errors.

package usb_pkg;

    // Sampled bus state as delivered by the line sampler
    typedef enum logic [1:0] {
        LS_SE0 = 2'b00,
        LS_J   = 2'b01,
        LS_K   = 2'b10,
        LS_SE1 = 2'b11
    } usb_line_state_t;

    localparam int         USB_STUFF_BITS_N = 6;
    localparam logic [7:0] USB_SYNC_VAL     = 8'h80;

    localparam logic [1:0] USB_ERR_STUFF = 2'd1;
    localparam logic [1:0] USB_ERR_ALIGN = 2'd2;
    localparam logic [1:0] USB_ERR_SE1   = 2'd3;

endpackage

module usb_rx_phy_decoder
    import usb_pkg::*;
#(
    parameter int         STUFF_BITS_N = USB_STUFF_BITS_N,
    parameter logic [7:0] SYNC_VAL     = USB_SYNC_VAL
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] line_state,
    input  logic       bit_stb,
    output logic       rx_active,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_eop,
    output logic       rx_err,
    output logic [1:0] rx_err_code
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SYNC,
        S_DATA,
        S_EOP,
        S_ERR
    } state_t;

    localparam logic [3:0] STUFF_N = 4'(STUFF_BITS_N);

    state_t          state;
    usb_line_state_t ls;
    usb_line_state_t prev_ls;
    logic [7:0]      sync_sr;
    logic [7:0]      data_sr;
    logic [2:0]      bit_cnt;
    logic [2:0]      byte_cnt;
    logic [3:0]      ones_cnt;
    logic [1:0]      se0_cnt;
    logic            seen_se0;

    logic            is_jk;
    logic            dec_bit;
    logic [7:0]      sync_nxt;
    logic [7:0]      data_nxt;

    assign ls       = usb_line_state_t'(line_state);
    assign is_jk    = (ls == LS_J) || (ls == LS_K);
    assign dec_bit  = (ls == prev_ls);
    assign sync_nxt = {dec_bit, sync_sr[7:1]};
    assign data_nxt = {dec_bit, data_sr[7:1]};

    // Receive FSM: advances one bit per strobe, pulses cleared every clk
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            prev_ls     <= LS_J;
            sync_sr     <= 8'h00;
            data_sr     <= 8'h00;
            bit_cnt     <= 3'd0;
            byte_cnt    <= 3'd0;
            ones_cnt    <= 4'd0;
            se0_cnt     <= 2'd0;
            seen_se0    <= 1'b0;
            rx_active   <= 1'b0;
            rx_data     <= 8'h00;
            rx_valid    <= 1'b0;
            rx_eop      <= 1'b0;
            rx_err      <= 1'b0;
            rx_err_code <= 2'd0;
        end else begin
            rx_valid <= 1'b0;
            rx_eop   <= 1'b0;
            rx_err   <= 1'b0;
            if (bit_stb) begin
                if (is_jk) begin
                    prev_ls <= ls;
                end
                unique case (state)
                    S_IDLE: begin
                        // A K out of idle is the first SYNC transition
                        if (ls == LS_K) begin
                            state   <= S_SYNC;
                            sync_sr <= 8'h00;
                            bit_cnt <= 3'd1;
                        end
                    end
                    S_SYNC: begin
                        unique case (ls)
                            LS_SE0: state <= S_IDLE;
                            LS_SE1: begin
                                state       <= S_ERR;
                                seen_se0    <= 1'b0;
                                rx_err      <= 1'b1;
                                rx_err_code <= USB_ERR_SE1;
                            end
                            LS_J, LS_K: begin
                                sync_sr <= sync_nxt;
                                bit_cnt <= bit_cnt + 3'd1;
                                if (bit_cnt == 3'd7) begin
                                    if (sync_nxt == SYNC_VAL) begin
                                        state     <= S_DATA;
                                        rx_active <= 1'b1;
                                        ones_cnt  <= 4'd1;
                                        byte_cnt  <= 3'd0;
                                    end else begin
                                        state <= S_IDLE;
                                    end
                                end
                            end
                        endcase
                    end
                    S_DATA: begin
                        unique case (ls)
                            LS_SE0: begin
                                if (byte_cnt == 3'd0) begin
                                    state   <= S_EOP;
                                    se0_cnt <= 2'd1;
                                end else begin
                                    state       <= S_ERR;
                                    seen_se0    <= 1'b1;
                                    rx_active   <= 1'b0;
                                    rx_err      <= 1'b1;
                                    rx_err_code <= USB_ERR_ALIGN;
                                end
                            end
                            LS_SE1: begin
                                state       <= S_ERR;
                                seen_se0    <= 1'b0;
                                rx_active   <= 1'b0;
                                rx_err      <= 1'b1;
                                rx_err_code <= USB_ERR_SE1;
                            end
                            LS_J, LS_K: begin
                                if (ones_cnt == STUFF_N) begin
                                    if (dec_bit) begin
                                        state       <= S_ERR;
                                        seen_se0    <= 1'b0;
                                        rx_active   <= 1'b0;
                                        rx_err      <= 1'b1;
                                        rx_err_code <= USB_ERR_STUFF;
                                    end else begin
                                        ones_cnt <= 4'd0;
                                    end
                                end else begin
                                    ones_cnt <= dec_bit ? ones_cnt + 4'd1 : 4'd0;
                                    data_sr  <= data_nxt;
                                    byte_cnt <= byte_cnt + 3'd1;
                                    if (byte_cnt == 3'd7) begin
                                        rx_data  <= data_nxt;
                                        rx_valid <= 1'b1;
                                    end
                                end
                            end
                        endcase
                    end
                    S_EOP: begin
                        unique case (ls)
                            LS_SE0: begin
                                if (se0_cnt != 2'd3) begin
                                    se0_cnt <= se0_cnt + 2'd1;
                                end
                            end
                            LS_J: begin
                                state     <= S_IDLE;
                                prev_ls   <= LS_J;
                                rx_active <= 1'b0;
                                rx_eop    <= 1'b1;
                            end
                            LS_K, LS_SE1: begin
                                state       <= S_ERR;
                                seen_se0    <= 1'b0;
                                rx_active   <= 1'b0;
                                rx_err      <= 1'b1;
                                rx_err_code <= USB_ERR_SE1;
                            end
                        endcase
                    end
                    S_ERR: begin
                        // Recover only after an SE0 directly followed by J
                        unique case (ls)
                            LS_SE0: seen_se0 <= 1'b1;
                            LS_J: begin
                                if (seen_se0) begin
                                    state   <= S_IDLE;
                                    prev_ls <= LS_J;
                                end
                            end
                            LS_K, LS_SE1: seen_se0 <= 1'b0;
                        endcase
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_usb_rx_phy_decoder.sv
// tb_usb_rx_phy_decoder: directed bench with a queue-based receive model
// compared every clk, plus hand-computed packet-level expectations.

module tb_usb_rx_phy_decoder;

    localparam logic [1:0] SE0 = 2'b00;
    localparam logic [1:0] J   = 2'b01;
    localparam logic [1:0] K   = 2'b10;
    localparam logic [1:0] SE1 = 2'b11;
    localparam int         SYNC_BYTE = 8'h80;

    localparam int M_IDLE = 0;
    localparam int M_SYNC = 1;
    localparam int M_DATA = 2;
    localparam int M_EOP  = 3;
    localparam int M_ERR  = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] line_state = J;
    logic       bit_stb = 1'b0;
    logic       rx_active;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_eop;
    logic       rx_err;
    logic [1:0] rx_err_code;

    always #5 clk = ~clk;

    usb_rx_phy_decoder dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .line_state  (line_state),
        .bit_stb     (bit_stb),
        .rx_active   (rx_active),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rx_eop      (rx_eop),
        .rx_err      (rx_err),
        .rx_err_code (rx_err_code)
    );

    int n_cmp = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [15:0] act,
                       input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)",
                     name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int         m_state = M_IDLE;
    logic [1:0] m_prev = J;
    bit         sq[$];
    bit         bq[$];
    int         m_ones = 0;
    bit         m_seen = 1'b0;
    logic       e_active = 1'b0;
    logic       e_valid = 1'b0;
    logic       e_eop = 1'b0;
    logic       e_err = 1'b0;
    logic [7:0] e_data = 8'h00;
    logic [1:0] e_code = 2'd0;
    bit         started = 1'b0;
    int         stb_idx = 0;

    task automatic m_raise(input logic [1:0] code, input bit seen);
        m_state  = M_ERR;
        e_err    = 1'b1;
        e_code   = code;
        e_active = 1'b0;
        m_seen   = seen;
    endtask

    task automatic m_step(input logic [1:0] ls);
        bit d;
        int v;
        d = (ls == m_prev);
        case (m_state)
            M_IDLE: begin
                if (ls == K) begin
                    sq.delete();
                    sq.push_back(1'b0);
                    m_state = M_SYNC;
                end
            end
            M_SYNC: begin
                if (ls == SE0) m_state = M_IDLE;
                else if (ls == SE1) m_raise(2'd3, 1'b0);
                else begin
                    sq.push_back(d);
                    if (sq.size() == 8) begin
                        v = 0;
                        foreach (sq[i]) v += int'(sq[i]) << i;
                        if (v == SYNC_BYTE) begin
                            m_state  = M_DATA;
                            e_active = 1'b1;
                            m_ones   = 1;
                            bq.delete();
                        end else begin
                            m_state = M_IDLE;
                        end
                    end
                end
            end
            M_DATA: begin
                if (ls == SE0) begin
                    if (bq.size() == 0) m_state = M_EOP;
                    else m_raise(2'd2, 1'b1);
                end else if (ls == SE1) begin
                    m_raise(2'd3, 1'b0);
                end else if (m_ones == 6) begin
                    if (d) m_raise(2'd1, 1'b0);
                    else m_ones = 0;
                end else begin
                    m_ones = d ? m_ones + 1 : 0;
                    bq.push_back(d);
                    if (bq.size() == 8) begin
                        v = 0;
                        foreach (bq[i]) v += int'(bq[i]) << i;
                        e_data  = 8'(v);
                        e_valid = 1'b1;
                        bq.delete();
                    end
                end
            end
            M_EOP: begin
                if (ls == J) begin
                    e_eop    = 1'b1;
                    e_active = 1'b0;
                    m_state  = M_IDLE;
                end else if (ls != SE0) begin
                    m_raise(2'd3, 1'b0);
                end
            end
            default: begin
                if (ls == SE0) m_seen = 1'b1;
                else if (ls == J && m_seen) m_state = M_IDLE;
                else if (ls != J) m_seen = 1'b0;
            end
        endcase
        if (ls == J || ls == K) m_prev = ls;
    endtask

    initial forever begin
        @(posedge clk);
        started = 1'b1;
        e_valid = 1'b0;
        e_eop   = 1'b0;
        e_err   = 1'b0;
        if (!rst_n) begin
            m_state  = M_IDLE;
            m_prev   = J;
            sq.delete();
            bq.delete();
            m_ones   = 0;
            m_seen   = 1'b0;
            e_active = 1'b0;
            e_data   = 8'h00;
            e_code   = 2'd0;
        end else if (bit_stb) begin
            stb_idx++;
            m_step(line_state);
        end
    end

    // ---------------- compare and event log ----------------
    logic [9:0] ev_q[$];
    logic [9:0] saved[$];
    int         cnt_valid = 0;
    int         cnt_eop = 0;
    int         cnt_err = 0;
    int         valid_idx = 0;
    int         eop_idx = 0;
    logic [7:0] last_byte = 8'h00;

    initial forever begin
        @(negedge clk);
        if (started) begin
            chk("rx_active", 16'(rx_active), 16'(e_active));
            chk("rx_valid", 16'(rx_valid), 16'(e_valid));
            chk("rx_eop", 16'(rx_eop), 16'(e_eop));
            chk("rx_err", 16'(rx_err), 16'(e_err));
            chk("rx_err_code", 16'(rx_err_code), 16'(e_code));
            if (e_valid) chk("rx_data", 16'(rx_data), 16'(e_data));
            if (rx_valid === 1'b1) begin
                ev_q.push_back({2'd1, rx_data});
                cnt_valid++;
                last_byte = rx_data;
                valid_idx = stb_idx;
            end
            if (rx_eop === 1'b1) begin
                ev_q.push_back({2'd2, 8'h00});
                cnt_eop++;
                eop_idx = stb_idx;
            end
            if (rx_err === 1'b1) begin
                ev_q.push_back({2'd3, 6'd0, rx_err_code});
                cnt_err++;
            end
        end
    end

    // ---------------- stimulus ----------------
    int         gap = 1;
    logic [1:0] lvl = J;
    int         tx_ones = 0;

    task automatic strobe(input logic [1:0] ls);
        line_state = ls;
        bit_stb = 1'b1;
        @(negedge clk);
        bit_stb = 1'b0;
        for (int i = 1; i < gap; i++) @(negedge clk);
    endtask

    task automatic send_bit(input bit b);
        if (!b) lvl = (lvl == J) ? K : J;
        strobe(lvl);
    endtask

    task automatic send_dbit(input bit b);
        send_bit(b);
        tx_ones = b ? tx_ones + 1 : 0;
        if (tx_ones == 6) begin
            send_bit(1'b0);
            tx_ones = 0;
        end
    endtask

    task automatic send_byte(input logic [7:0] v);
        for (int i = 0; i < 8; i++) send_dbit(v[i]);
    endtask

    task automatic send_raw(input logic [15:0] pat);
        for (int i = 7; i >= 0; i--) strobe(pat[2*i +: 2]);
    endtask

    task automatic send_sync();
        send_raw({K, J, K, J, K, J, K, K});
        lvl = K;
        tx_ones = 1;
    endtask

    task automatic send_eop();
        strobe(SE0);
        strobe(SE0);
        strobe(J);
        lvl = J;
    endtask

    task automatic idle(input int n);
        repeat (n) strobe(J);
        lvl = J;
    endtask

    task automatic clear_log();
        ev_q.delete();
        cnt_valid = 0;
        cnt_eop = 0;
        cnt_err = 0;
        valid_idx = 0;
        eop_idx = 0;
    endtask

    task automatic run_stream();
        idle(2);
        send_sync();
        send_byte(8'h5A);
        send_byte(8'hC3);
        send_eop();
        idle(3);
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_active"}, 16'(rx_active), 16'd0);
        chk({tag, "_valid"}, 16'(rx_valid), 16'd0);
        chk({tag, "_data"}, 16'(rx_data), 16'd0);
        chk({tag, "_eop"}, 16'(rx_eop), 16'd0);
        chk({tag, "_err"}, 16'(rx_err), 16'd0);
        chk({tag, "_code"}, 16'(rx_err_code), 16'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: run did not finish in time");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        line_state = J;
        bit_stb = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk_outputs_zero("reset");
        rst_n = 1'b1;
        idle(3);

        // good packet 0xA5
        clear_log();
        send_sync();
        send_byte(8'hA5);
        send_eop();
        idle(3);
        chk("a5_nvalid", 16'(cnt_valid), 16'd1);
        chk("a5_byte", 16'(last_byte), 16'h00A5);
        chk("a5_neop", 16'(cnt_eop), 16'd1);
        chk("a5_nerr", 16'(cnt_err), 16'd0);
        chk("a5_eop_lag", 16'(eop_idx - valid_idx), 16'd3);
        chk("a5_active", 16'(rx_active), 16'd0);

        // 0xFF with a stuffed zero
        clear_log();
        send_sync();
        send_byte(8'hFF);
        send_eop();
        idle(3);
        chk("ff_nvalid", 16'(cnt_valid), 16'd1);
        chk("ff_byte", 16'(last_byte), 16'h00FF);
        chk("ff_nerr", 16'(cnt_err), 16'd0);
        chk("ff_neop", 16'(cnt_eop), 16'd1);

        // stuff bit replaced by a one
        clear_log();
        send_sync();
        repeat (6) send_bit(1'b1);
        strobe(SE0);
        strobe(J);
        lvl = J;
        idle(2);
        chk("stuff_nerr", 16'(cnt_err), 16'd1);
        chk("stuff_code", 16'(rx_err_code), 16'd1);
        chk("stuff_nvalid", 16'(cnt_valid), 16'd0);
        chk("stuff_neop", 16'(cnt_eop), 16'd0);

        // 12 data bits then SE0: misalignment
        clear_log();
        send_sync();
        send_byte(8'h5A);
        send_dbit(1'b1);
        send_dbit(1'b0);
        send_dbit(1'b1);
        send_dbit(1'b0);
        strobe(SE0);
        strobe(J);
        lvl = J;
        idle(2);
        chk("align_nvalid", 16'(cnt_valid), 16'd1);
        chk("align_byte", 16'(last_byte), 16'h005A);
        chk("align_nerr", 16'(cnt_err), 16'd1);
        chk("align_code", 16'(rx_err_code), 16'd2);
        chk("align_neop", 16'(cnt_eop), 16'd0);
        clear_log();
        send_sync();
        send_byte(8'h3C);
        send_eop();
        idle(3);
        chk("after_align_byte", 16'(last_byte), 16'h003C);
        chk("after_align_nvalid", 16'(cnt_valid), 16'd1);
        chk("after_align_neop", 16'(cnt_eop), 16'd1);

        // corrupted SYNC, then a clean packet straight after
        clear_log();
        send_raw({K, J, K, K, J, K, K, K});
        lvl = K;
        chk("badsync_active", 16'(rx_active), 16'd0);
        send_sync();
        send_byte(8'h81);
        send_eop();
        idle(3);
        chk("badsync_nvalid", 16'(cnt_valid), 16'd1);
        chk("badsync_byte", 16'(last_byte), 16'h0081);
        chk("badsync_neop", 16'(cnt_eop), 16'd1);
        chk("badsync_nerr", 16'(cnt_err), 16'd0);

        // SE1 in the middle of 0x3C
        clear_log();
        send_sync();
        send_dbit(1'b0);
        send_dbit(1'b0);
        send_dbit(1'b1);
        send_dbit(1'b1);
        strobe(SE1);
        chk("se1_active", 16'(rx_active), 16'd0);
        strobe(SE0);
        strobe(J);
        lvl = J;
        idle(2);
        chk("se1_nerr", 16'(cnt_err), 16'd1);
        chk("se1_code", 16'(rx_err_code), 16'd3);
        chk("se1_nvalid", 16'(cnt_valid), 16'd0);

        // reset pulse mid-packet
        clear_log();
        send_sync();
        send_dbit(1'b1);
        send_dbit(1'b0);
        send_dbit(1'b1);
        send_dbit(1'b0);
        rst_n = 1'b0;
        @(negedge clk);
        chk_outputs_zero("midrst");
        rst_n = 1'b1;
        lvl = J;
        idle(2);
        chk("midrst_neop", 16'(cnt_eop), 16'd0);
        send_sync();
        send_byte(8'h3C);
        send_eop();
        idle(3);
        chk("midrst_nvalid", 16'(cnt_valid), 16'd1);
        chk("midrst_byte", 16'(last_byte), 16'h003C);
        chk("midrst_neop2", 16'(cnt_eop), 16'd1);
        chk("midrst_nerr", 16'(cnt_err), 16'd0);

        // same stream, strobe every clk versus every 4th clk
        gap = 1;
        clear_log();
        run_stream();
        saved = ev_q;
        gap = 4;
        clear_log();
        run_stream();
        gap = 1;
        chk("gap_saved_len", 16'(saved.size()), 16'd3);
        if (saved.size() == 3) begin
            chk("gap_ev0", 16'(saved[0]), 16'({2'd1, 8'h5A}));
            chk("gap_ev1", 16'(saved[1]), 16'({2'd1, 8'hC3}));
            chk("gap_ev2", 16'(saved[2]), 16'({2'd2, 8'h00}));
        end
        chk("gap_len", 16'(ev_q.size()), 16'(saved.size()));
        for (int i = 0; i < saved.size() && i < ev_q.size(); i++) begin
            chk("gap_seq", 16'(ev_q[i]), 16'(saved[i]));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule
